// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding, status codes and default width for the GCD front end
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_TRIVIAL = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

endpackage

// File: rtl/gcd_frontend_if.sv
// rtl/gcd_frontend_if.sv - operand, core and result handshake bundle of the GCD front end
interface gcd_frontend_if #(
    parameter int WIDTH = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             core_start_o;
    logic [WIDTH-1:0] core_zahl1_o;
    logic [WIDTH-1:0] core_zahl2_o;
    logic             core_valid_i;
    logic [WIDTH-1:0] core_result_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [WIDTH-1:0] res_o;
    logic [1:0]       res_status_o;
    logic             busy_o;

    // slave: the front end itself; master: everything around it
    modport slave (
        input  in_valid_i, a_i, b_i, core_valid_i, core_result_i, res_ready_i,
        output in_ready_o, core_start_o, core_zahl1_o, core_zahl2_o,
               res_valid_o, res_o, res_status_o, busy_o
    );

    modport master (
        output in_valid_i, a_i, b_i, core_valid_i, core_result_i, res_ready_i,
        input  in_ready_o, core_start_o, core_zahl1_o, core_zahl2_o,
               res_valid_o, res_o, res_status_o, busy_o
    );
endinterface

// File: rtl/gcd_timeout_counter.sv
// rtl/gcd_timeout_counter.sv - WAIT-phase cycle counter, expired on its final count
module gcd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/gcd_frontend.sv
// rtl/gcd_frontend.sv - accepts operand pairs, resolves trivial GCDs, drives the core under a timeout
module gcd_frontend
    import gcd_pkg::*;
#(
    parameter int WIDTH          = GCD_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           clk,
    input  logic           rst,
    gcd_frontend_if.slave  bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_zahl1;
    logic [WIDTH-1:0] r_zahl2;
    logic [WIDTH-1:0] r_res;
    logic [1:0]       r_status;
    logic             r_start;
    logic             r_res_valid;
    logic             r_busy;

    logic             w_accept;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_equal;
    logic             w_a_gt_b;
    logic             w_trivial;
    logic [WIDTH-1:0] w_trivial_res;
    logic             w_expired;

    assign bus.in_ready_o = (r_state == ST_IDLE) && !rst;
    assign w_accept       = bus.in_valid_i && bus.in_ready_o;

    assign w_a_zero  = (r_a == '0);
    assign w_b_zero  = (r_b == '0);
    assign w_equal   = (r_a == r_b);
    assign w_a_gt_b  = (r_a > r_b);
    assign w_trivial = w_a_zero || w_b_zero || w_equal;

    // Priority order matters only for documentation: every trivial case lands on the non-zero operand
    always_comb begin
        w_trivial_res = r_a;
        if (w_a_zero && w_b_zero) begin
            w_trivial_res = '0;
        end else if (w_a_zero) begin
            w_trivial_res = r_b;
        end else if (w_b_zero) begin
            w_trivial_res = r_a;
        end
    end

    gcd_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == ST_ISSUE),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_zahl1     <= '0;
            r_zahl2     <= '0;
            r_res       <= '0;
            r_status    <= STAT_OK;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.a_i;
                        r_b     <= bus.b_i;
                        r_busy  <= 1'b1;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_trivial) begin
                        r_res       <= w_trivial_res;
                        r_status    <= STAT_TRIVIAL;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else begin
                        r_zahl1 <= w_a_gt_b ? r_a : r_b;
                        r_zahl2 <= w_a_gt_b ? r_b : r_a;
                        r_start <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_start <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result in the final counted cycle beats the timeout
                    if (bus.core_valid_i) begin
                        r_res       <= bus.core_result_i;
                        r_status    <= STAT_OK;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else if (w_expired) begin
                        r_res       <= '0;
                        r_status    <= STAT_TIMEOUT;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.res_ready_i) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.core_start_o = r_start;
    assign bus.core_zahl1_o = r_zahl1;
    assign bus.core_zahl2_o = r_zahl2;
    assign bus.res_valid_o  = r_res_valid;
    assign bus.res_o        = r_res;
    assign bus.res_status_o = r_status;
    assign bus.busy_o       = r_busy;
endmodule

// File: tb/tb_gcd_frontend.sv
// tb/tb_gcd_frontend.sv - directed self-checking bench for gcd_frontend
module tb_gcd_frontend;
    localparam int W  = 16;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_start;

    gcd_frontend_if #(.WIDTH(W)) bus ();

    gcd_frontend #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.core_start_o === 1'b1) n_start++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        while (bus.in_ready_o !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("send_ready", 32'(guard < 20), 32'd1);
        bus.in_valid_i = 1'b1;
        bus.a_i        = a;
        bus.b_i        = b;
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        chk("drain_in_ready", 32'(bus.in_ready_o), 32'd1);
    endtask

    task automatic trivial(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
        int s0;
        s0 = n_start;
        send(a, b);
        chk("triv_early_valid", 32'(bus.res_valid_o), 32'd0);
        tick();
        chk("triv_valid", 32'(bus.res_valid_o), 32'd1);
        chk("triv_res", 32'(bus.res_o), 32'(exp));
        chk("triv_status", 32'(bus.res_status_o), 32'd1);
        chk("triv_no_start", 32'(n_start - s0), 32'd0);
        drain();
    endtask

    task automatic core_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] z1, input logic [W-1:0] z2, input logic [W-1:0] r);
        int s0;
        s0 = n_start;
        send(a, b);
        tick();
        chk("core_start", 32'(bus.core_start_o), 32'd1);
        chk("core_zahl1", 32'(bus.core_zahl1_o), 32'(z1));
        chk("core_zahl2", 32'(bus.core_zahl2_o), 32'(z2));
        for (int i = 0; i < 10; i++) tick();
        bus.core_valid_i  = 1'b1;
        bus.core_result_i = r;
        tick();
        bus.core_valid_i  = 1'b0;
        bus.core_result_i = 16'hdead;
        chk("core_valid", 32'(bus.res_valid_o), 32'd1);
        chk("core_res", 32'(bus.res_o), 32'(r));
        chk("core_status", 32'(bus.res_status_o), 32'd0);
        chk("core_zahl1_hold", 32'(bus.core_zahl1_o), 32'(z1));
        chk("core_one_start", 32'(n_start - s0), 32'd1);
        drain();
    endtask

    initial begin
        int cyc;
        n_cmp = 0;
        n_err = 0;
        n_start = 0;
        rst = 1'b1;
        bus.in_valid_i    = 1'b0;
        bus.a_i           = '0;
        bus.b_i           = '0;
        bus.core_valid_i  = 1'b0;
        bus.core_result_i = '0;
        bus.res_ready_i   = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_start", 32'(bus.core_start_o), 32'd0);
        chk("rst_zahl1", 32'(bus.core_zahl1_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);

        core_op(16'd48, 16'd18, 16'd48, 16'd18, 16'd6);
        core_op(16'd18, 16'd48, 16'd48, 16'd18, 16'd6);

        trivial(16'd0,  16'd7,  16'd7);
        trivial(16'd7,  16'd0,  16'd7);
        trivial(16'd12, 16'd12, 16'd12);
        trivial(16'd0,  16'd0,  16'd0);
        trivial(16'hffff, 16'd0, 16'hffff);

        // Timeout with core silent
        send(16'd5, 16'd3);
        tick();
        chk("to_start", 32'(bus.core_start_o), 32'd1);
        cyc = 0;
        while (bus.res_valid_o !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("to_latency", 32'(cyc), 32'(TO + 1));
        chk("to_res", 32'(bus.res_o), 32'd0);
        chk("to_status", 32'(bus.res_status_o), 32'd2);
        drain();

        // Core result in the last WAIT cycle wins over the timeout
        send(16'd9, 16'd6);
        tick();
        for (int i = 0; i < TO; i++) tick();
        chk("last_no_valid", 32'(bus.res_valid_o), 32'd0);
        bus.core_valid_i  = 1'b1;
        bus.core_result_i = 16'd3;
        tick();
        bus.core_valid_i  = 1'b0;
        chk("last_valid", 32'(bus.res_valid_o), 32'd1);
        chk("last_res", 32'(bus.res_o), 32'd3);
        chk("last_status", 32'(bus.res_status_o), 32'd0);
        drain();

        // Back-pressure: result held, new operands ignored
        send(16'd0, 16'd9);
        tick();
        bus.in_valid_i = 1'b1;
        bus.a_i        = 16'd100;
        bus.b_i        = 16'd40;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.res_valid_o), 32'd1);
            chk("bp_res", 32'(bus.res_o), 32'd9);
            chk("bp_status", 32'(bus.res_status_o), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
        end
        bus.in_valid_i = 1'b0;
        drain();
        chk("bp_idle_busy", 32'(bus.busy_o), 32'd0);

        // Reset while waiting on the core
        send(16'd30, 16'd12);
        tick();
        tick();
        tick();
        chk("rw_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        tick();
        chk("rw_in_ready_rst", 32'(bus.in_ready_o), 32'd0);
        rst = 1'b0;
        bus.core_valid_i  = 1'b1;
        bus.core_result_i = 16'd6;
        cyc = n_start;
        tick();
        bus.core_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_res_valid", 32'(bus.res_valid_o), 32'd0);
        end
        chk("rw_res", 32'(bus.res_o), 32'd0);
        chk("rw_status", 32'(bus.res_status_o), 32'd0);
        chk("rw_zahl1", 32'(bus.core_zahl1_o), 32'd0);
        chk("rw_zahl2", 32'(bus.core_zahl2_o), 32'd0);
        chk("rw_busy_after", 32'(bus.busy_o), 32'd0);
        chk("rw_no_restart", 32'(n_start - cyc), 32'd0);
        chk("rw_in_ready", 32'(bus.in_ready_o), 32'd1);

        trivial(16'd21, 16'd0, 16'd21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gcd_frontend.md
# gcd_frontend

Operand front end and result buffer for the Euclidean GCD core. Accepts an operand pair through a valid/ready handshake, resolves trivial cases locally, orders and holds the operands for the core, and issues a one-cycle start. It then waits for the core's termination flag under a timeout and presents the result downstream through a second valid/ready handshake. Sits directly between the system bus side and the GCD datapath/controller: it drives the datapath's operand and start inputs and consumes its valid/result outputs.

## Interface
- WIDTH, 16, operand/result width
- TIMEOUT_CYCLES, 4096, maximum WAIT cycles before abort (≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  front end can accept a pair
- a_i, b_i  in  WIDTH  unsigned operands
- core_start_o  out  1  one-cycle start pulse to core
- core_zahl1_o, core_zahl2_o  out  WIDTH  ordered operands to core (zahl1 ≥ zahl2)
- core_valid_i  in  1  core termination flag (result valid)
- core_result_i  in  WIDTH  core GCD result
- res_valid_o  out  1  result valid
- res_ready_i  in  1  downstream accepts result
- res_o  out  WIDTH  GCD result
- res_status_o  out  2  00 OK (core), 01 TRIVIAL (local), 10 TIMEOUT, 11 unused
- busy_o  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, CHECK, ISSUE, WAIT, OUT.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o, register a_i, b_i → CHECK.
- CHECK (1 cycle), first match wins:
  - a=0, b=0 → res 0, TRIVIAL → OUT
  - a=0 → res b, TRIVIAL → OUT; b=0 → res a, TRIVIAL → OUT
  - a=b → res a, TRIVIAL → OUT
  - else load core_zahl1_o=max(a,b), core_zahl2_o=min(a,b) → ISSUE
- ISSUE (1 cycle): core_start_o=1; clear timeout counter → WAIT.
- WAIT: counter increments each cycle. core_valid_i=1 → capture core_result_i, status OK → OUT. Counter reaches TIMEOUT_CYCLES−1 with no valid → res 0, TIMEOUT → OUT. Valid and timeout in the same cycle: valid wins.
- OUT: res_valid_o=1; res_o/res_status_o stable until res_valid_o & res_ready_i → IDLE.
- core_zahl1_o/core_zahl2_o held constant from ISSUE until next CHECK load; never change during WAIT.
- core_valid_i ignored outside WAIT. in_valid_i ignored outside IDLE (no skid buffer).
- Comparisons unsigned, full WIDTH; no arithmetic beyond compare/select.

## Timing
- Reset: state IDLE; core_start_o, res_valid_o, busy_o, res_o, res_status_o, core_zahl1_o, core_zahl2_o, counter all 0. in_ready_o=0 while rst high, 1 in first cycle after.
- All outputs registered except in_ready_o (= state==IDLE & ~rst).
- Trivial path: pair accepted at edge T → res_valid_o high from edge T+2.
- Core path: accepted at T → core_start_o high cycle after T+2 edge (exactly one cycle) → result valid the cycle after core_valid_i sampled high.
- Timeout: res_valid_o high TIMEOUT_CYCLES+1 cycles after ISSUE edge.
- Back-to-back: in_ready_o high the cycle after the result handshake; minimum initiation interval 3 cycles (trivial).
- rst mid-operation (any state): immediate return to reset values next edge; pending result discarded; core_start_o not re-issued.

## Structure
- Shared package gcd_pkg: state encoding (IDLE..OUT), status codes STAT_OK/STAT_TRIVIAL/STAT_TIMEOUT, default WIDTH.
- One sub-module: gcd_timeout_counter (clear, enable, parameter TIMEOUT_CYCLES, output expired); clog2-sized.
- Trivial detection/ordering is combinational logic inside gcd_frontend.

## Test plan
- (48,18), core asserts core_valid_i with 6 ten cycles after start → core_zahl1_o=48, core_zahl2_o=18, one start pulse, res_o=6, status 00.
- (18,48) → operands swapped: core_zahl1_o=48, core_zahl2_o=18; result 6, status 00.
- (0,7), (7,0), (12,12), (0,0) → res 7, 7, 12, 0, status 01, latency 2, core_start_o never asserted.
- TIMEOUT_CYCLES=16, core_valid_i held low → res_o=0, status 10, res_valid_o 17 cycles after ISSUE; core_valid_i arriving in final cycle → status 00 instead.
- Result with res_ready_i low 5 cycles → res_o/res_status_o stable, in_ready_o low, new in_valid_i ignored; handshake → IDLE next cycle.
- rst asserted during WAIT, core_valid_i pulsed one cycle later → all outputs 0, no result emitted, in_ready_o high after rst drops.
